// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory. Port 0 has fixed
// priority; a saturating wait counter hands port 1 a conflict after STARVE_LIM losses.
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic          CLK,
    input  logic          start,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflict_ct
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  gnt;
    logic [3:0]  wait1_reg;
    logic [3:0]  wait1_next;
    logic [15:0] conflict_ct_reg;
    logic [15:0] conflict_ct_next;

    assign req = {req1, req0};
    assign we  = {we1, we0};

    always_comb begin
        gnt = 2'b00;
        if (!start) begin
            if (req[0] && req[1]) begin
                if (wait1_reg == LIM) gnt[1] = 1'b1;
                else                  gnt[0] = 1'b1;
            end else if (req[0]) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Idle and reset both drive zeros so memory sees a quiet bus.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (gnt[0]) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we0;
        end else if (gnt[1]) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we1;
        end
    end

    always_comb begin
        wait1_next = wait1_reg;
        if (!req[1] || gnt[1])    wait1_next = 4'd0;
        else if (wait1_reg < LIM) wait1_next = wait1_reg + 4'd1;

        conflict_ct_next = conflict_ct_reg;
        if (req[0] && req[1] && (conflict_ct_reg != 16'hFFFF))
            conflict_ct_next = conflict_ct_reg + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            wait1_reg       <= 4'd0;
            conflict_ct_reg <= 16'd0;
        end else begin
            wait1_reg       <= wait1_next;
            conflict_ct_reg <= conflict_ct_next;
        end
    end

    assign conflict_ct = conflict_ct_reg;

    // Per-port read response: capture memory data in the grant cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        logic          rvalid_reg;
        logic [DW-1:0] rdata_reg;

        always_ff @(posedge CLK) begin
            if (start) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
            end else begin
                rvalid_reg <= gnt[gi] & ~we[gi];
                if (gnt[gi] && !we[gi]) rdata_reg <= mem_rdata;
            end
        end
    end

    // A response already in flight when start rises is suppressed immediately.
    assign rvalid0 = g_resp[0].rvalid_reg & ~start;
    assign rvalid1 = g_resp[1].rvalid_reg & ~start;
    assign rdata0  = g_resp[0].rdata_reg;
    assign rdata1  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory behind it.
module tb_dmem_arbiter;

    logic       CLK;
    logic       start;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
    logic [15:0] conflict_ct;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [256];

    dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIM(4)) dut (
        .CLK(CLK), .start(start),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .conflict_ct(conflict_ct)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = ~8'(i);
    end
    always @(posedge CLK) if (mem_we) mem_model[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_model[mem_addr];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        addr0 = 8'h11; addr1 = 8'h22; wdata0 = 8'h33; wdata1 = 8'h44;
        #1;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_grants: got gnt0=%b gnt1=%b mem_we=%b expected 0 0 0", gnt0, gnt1, mem_we);
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h expected 00 00", mem_addr, mem_wdata);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (conflict_ct !== 16'd0 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_state%0d: got ct=%h rv0=%b rv1=%b g0=%b g1=%b expected 0 0 0 0 0",
                         c, conflict_ct, rvalid0, rvalid1, gnt0, gnt1);
            end
        end
        start = 1'b0; we0 = 1'b0; we1 = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        $display("reset: done");
    endtask

    task automatic test_single_port();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'hA5;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL p1_write: got g1=%b g0=%b we=%b addr=%h wd=%h expected 1 0 1 10 a5",
                     gnt1, gnt0, mem_we, mem_addr, mem_wdata);
        end
        tick();
        $display("p1 write addr=10 data=a5");
        checks++;
        if (rvalid1 !== 1'b0) begin
            errors++;
            $display("FAIL p1_write_no_rvalid: got rvalid1=%b expected 0", rvalid1);
        end
        we1 = 1'b0;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL p1_read_gnt: got g1=%b we=%b addr=%h expected 1 0 10", gnt1, mem_we, mem_addr);
        end
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'hA5 || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL p1_read_data: got rv1=%b rd1=%h rv0=%b expected 1 a5 0", rvalid1, rdata1, rvalid0);
        end
        $display("p1 read addr=10 data=%h", rdata1);
        req1 = 1'b0;
        tick();
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 8'hA5) begin
            errors++;
            $display("FAIL p1_hold: got rv1=%b rd1=%h expected 0 a5", rvalid1, rdata1);
        end
    endtask

    task automatic test_conflict_priority();
        logic exp1;
        logic prev1;
        int   deny;
        deny = 0;
        prev1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
        for (int i = 0; i < 10; i++) begin
            exp1 = ((i % 5) == 4);
            #1;
            checks++;
            if (gnt0 !== ~exp1 || gnt1 !== exp1) begin
                errors++;
                $display("FAIL conflict_seq[%0d]: got g0=%b g1=%b expected %b %b", i, gnt0, gnt1, ~exp1, exp1);
            end
            if (gnt1) deny = 0; else deny++;
            checks++;
            if (deny > 4) begin
                errors++;
                $display("FAIL starve_bound[%0d]: got %0d denied cycles expected at most 4", i, deny);
            end
            tick();
            checks++;
            if (rvalid1 !== exp1 || rvalid0 !== ~exp1) begin
                errors++;
                $display("FAIL conflict_rvalid[%0d]: got rv0=%b rv1=%b expected %b %b", i, rvalid0, rvalid1, ~exp1, exp1);
            end
            $display("conflict cycle %0d granted port %0d", i, exp1 ? 1 : 0);
            prev1 = exp1;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (conflict_ct !== 16'd10) begin
            errors++;
            $display("FAIL conflict_count: got %0d expected 10", conflict_ct);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h3C;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        #1;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL simul_first: got g0=%b g1=%b we=%b addr=%h wd=%h expected 1 0 1 20 3c",
                     gnt0, gnt1, mem_we, mem_addr, mem_wdata);
        end
        tick();
        req0 = 1'b0;
        #1;
        checks++;
        if (gnt1 !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h20) begin
            errors++;
            $display("FAIL simul_second: got g1=%b we=%b addr=%h expected 1 0 20", gnt1, mem_we, mem_addr);
        end
        tick();
        req1 = 1'b0;
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C || conflict_ct !== 16'd11) begin
            errors++;
            $display("FAIL simul_raw: got rv1=%b rd1=%h ct=%0d expected 1 3c 11", rvalid1, rdata1, conflict_ct);
        end
        $display("simultaneous p0 write 20=3c, p1 read %h", rdata1);
        tick();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
        #1;
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL midrd_gnt: got gnt0=%b expected 1", gnt0);
        end
        tick();
        checks++;
        if (rdata0 !== 8'hFA) begin
            errors++;
            $display("FAIL midrd_data: got rdata0=%h expected fa", rdata0);
        end
        start = 1'b1;
        #1;
        checks++;
        if (rvalid0 !== 1'b0 || gnt0 !== 1'b0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL midrd_reset: got rv0=%b g0=%b addr=%h expected 0 0 00", rvalid0, gnt0, mem_addr);
        end
        tick();
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h00 || conflict_ct !== 16'd0) begin
            errors++;
            $display("FAIL midrd_after: got rv0=%b rd0=%h ct=%0d expected 0 00 0", rvalid0, rdata0, conflict_ct);
        end
        $display("reset mid-read: rvalid0=%b", rvalid0);
        start = 1'b0; req0 = 1'b0;
        tick();
    endtask

    task automatic test_conflict_sat();
        int deny;
        int max_deny;
        deny = 0;
        max_deny = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h01;
        for (int k = 0; k < 65534; k++) begin
            #1;
            if (gnt1) deny = 0; else deny++;
            if (deny > max_deny) max_deny = deny;
            tick();
        end
        checks++;
        if (conflict_ct !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: got %h expected fffe", conflict_ct);
        end
        tick();
        checks++;
        if (conflict_ct !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hit: got %h expected ffff", conflict_ct);
        end
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (conflict_ct !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h expected ffff", conflict_ct);
        end
        checks++;
        if (max_deny > 4) begin
            errors++;
            $display("FAIL sat_starve: got %0d denied cycles expected at most 4", max_deny);
        end
        $display("conflict_ct saturated at %h", conflict_ct);
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_conflict_priority();
        test_simultaneous();
        test_reset_mid_read();
        test_conflict_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
